// File: rtl/seg_hs_reg_pkg.sv
// Shared pipeline definitions: reset PC, NOP field encodings, per-stage
// payload structs and their widths, plus a small occupancy helper.
package seg_hs_reg_pkg;

  typedef logic [1:0] occ_t;

  localparam logic [31:0] RESET_PC       = 32'h1c00_0000;
  localparam logic [31:0] RESET_PC_PLUS4 = RESET_PC + 32'd4;

  // andi r0, r0, 0 -- the canonical bubble instruction
  localparam logic [31:0] NOP_INSTR  = 32'h0340_0000;
  localparam logic [3:0]  ALU_OP_ADD = 4'd0;

  typedef enum logic [1:0] {
    RF_WD_ALU = 2'd0,
    RF_WD_MEM = 2'd1,
    RF_WD_PC4 = 2'd2
  } rf_wd_sel_e;

  typedef enum logic [1:0] {
    DMEM_NONE  = 2'd0,
    DMEM_LOAD  = 2'd1,
    DMEM_STORE = 2'd2
  } dmem_access_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0]  pc;
    logic [3:0]   alu_op;
    logic [31:0]  src1;
    logic [31:0]  src2;
    logic [31:0]  store_data;
    rf_wd_sel_e   rf_wd_sel;
    dmem_access_e dmem_access;
    logic         rf_we;
    logic [4:0]   rf_waddr;
  } id_ex_t;

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  alu_result;
    logic [31:0]  store_data;
    rf_wd_sel_e   rf_wd_sel;
    dmem_access_e dmem_access;
    logic         rf_we;
    logic [4:0]   rf_waddr;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

  // Bubble payloads: an ADD writing nothing, no memory access
  localparam if_id_t IF_ID_NOP = '{pc: RESET_PC, instr: NOP_INSTR};

  localparam id_ex_t ID_EX_NOP = '{
    pc:          RESET_PC,
    alu_op:      ALU_OP_ADD,
    src1:        32'd0,
    src2:        32'd0,
    store_data:  32'd0,
    rf_wd_sel:   RF_WD_ALU,
    dmem_access: DMEM_NONE,
    rf_we:       1'b0,
    rf_waddr:    5'd0
  };

  localparam ex_mem_t EX_MEM_NOP = '{
    pc:          RESET_PC,
    alu_result:  32'd0,
    store_data:  32'd0,
    rf_wd_sel:   RF_WD_ALU,
    dmem_access: DMEM_NONE,
    rf_we:       1'b0,
    rf_waddr:    5'd0
  };

  localparam mem_wb_t MEM_WB_NOP = '{
    pc:       RESET_PC,
    wdata:    32'd0,
    rf_we:    1'b0,
    rf_waddr: 5'd0
  };

  // Number of occupied entries from the two valid bits
  function automatic occ_t occ_count(input logic a, input logic b);
    return occ_t'({1'b0, a}) + occ_t'({1'b0, b});
  endfunction

endpackage

// File: rtl/seg_hs_reg_if.sv
// Handshake bundle for one pipeline segment: upstream valid/ready/data/commit,
// downstream valid/ready/data/commit, stage controls and occupancy.
interface seg_hs_reg_if #(
  parameter int W = 32
);
  import seg_hs_reg_pkg::*;

  logic         flush;
  logic         stall;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_commit;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_commit;
  occ_t         occupancy;

  // The segment register itself
  modport slave (
    input  flush, stall, in_valid, in_data, in_commit, out_ready,
    output in_ready, out_valid, out_data, out_commit, occupancy
  );

  // Whoever drives the segment (surrounding stages or a bench)
  modport master (
    output flush, stall, in_valid, in_data, in_commit, out_ready,
    input  in_ready, out_valid, out_data, out_commit, occupancy
  );

endinterface

// File: rtl/seg_hs_reg_slot.sv
// One storage entry: valid bit, payload and commit flag, with
// clear-to-NOP, load and implicit hold.
module seg_hs_reg_slot #(
  parameter int           W           = 32,
  parameter logic [W-1:0] NOP_PAYLOAD = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d_data,
  input  logic         d_commit,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         commit
);

  // Clear beats load; with neither asserted the entry holds its contents
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid  <= 1'b0;
      data   <= NOP_PAYLOAD;
      commit <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      data   <= d_data;
      commit <= d_commit;
    end
  end

endmodule

// File: rtl/seg_hs_reg.sv
// Generic pipeline segment register with valid/ready handshake, flush/stall
// control, commit tracking and an optional second (skid) entry that makes
// in_ready independent of out_ready.
module seg_hs_reg
  import seg_hs_reg_pkg::*;
#(
  parameter int           W           = 32,
  parameter logic [W-1:0] NOP_PAYLOAD = {W{1'b0}},
  parameter int           SKID        = 1
) (
  input  logic          clk,
  input  logic          rst,
  seg_hs_reg_if.slave   bus
);

  logic         xfer_en;
  logic         in_fire;
  logic         out_fire;

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         main_commit;
  logic         main_load;
  logic         main_clr;
  logic [W-1:0] main_d_data;
  logic         main_d_commit;

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         skid_commit;

  // Transfers are only possible when neither stall nor flush is active
  assign xfer_en  = ~bus.stall & ~bus.flush;
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  assign bus.out_valid  = main_valid & xfer_en;
  assign bus.out_data   = main_data;
  assign bus.out_commit = main_commit;
  assign bus.occupancy  = occ_count(main_valid, skid_valid);

  // Main refills from the skid entry when one is waiting (it is older),
  // otherwise from the input when it is empty or being drained this cycle.
  assign main_load     = (in_fire & (~main_valid | out_fire)) | (out_fire & skid_valid);
  assign main_clr      = bus.flush | (out_fire & ~skid_valid & ~in_fire);
  assign main_d_data   = skid_valid ? skid_data : bus.in_data;
  assign main_d_commit = skid_valid ? skid_commit : bus.in_commit;

  seg_hs_reg_slot #(
    .W           (W),
    .NOP_PAYLOAD (NOP_PAYLOAD)
  ) u_main (
    .clk      (clk),
    .rst      (rst),
    .clr      (main_clr),
    .load     (main_load),
    .d_data   (main_d_data),
    .d_commit (main_d_commit),
    .valid    (main_valid),
    .data     (main_data),
    .commit   (main_commit)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;
      logic skid_clr;

      // Ready depends only on registered skid state, never on out_ready
      assign bus.in_ready = xfer_en & ~skid_valid;

      // Input parks in skid when main is full and not draining
      assign skid_load = in_fire & main_valid & ~out_fire;
      assign skid_clr  = bus.flush | (out_fire & skid_valid);

      seg_hs_reg_slot #(
        .W           (W),
        .NOP_PAYLOAD (NOP_PAYLOAD)
      ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .clr      (skid_clr),
        .load     (skid_load),
        .d_data   (bus.in_data),
        .d_commit (bus.in_commit),
        .valid    (skid_valid),
        .data     (skid_data),
        .commit   (skid_commit)
      );
    end else begin : g_no_skid
      // Single entry: accept when empty or when the held item leaves now
      assign bus.in_ready = xfer_en & (~main_valid | bus.out_ready);
      assign skid_valid   = 1'b0;
      assign skid_data    = NOP_PAYLOAD;
      assign skid_commit  = 1'b0;
    end
  endgenerate

endmodule

// File: doc/seg_hs_reg.md
Name: seg_hs_reg

Overview:
- Parametrised pipeline segment register that sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- It replaces the fixed per-stage segment registers with one generic block.
- Payload width is a parameter; the NOP/bubble payload is a parameter.
- It adds a valid/ready handshake and an optional 2-entry skid buffer (breaks the combinational ready path), on top of the existing flush/stall controls and commit tracking.

Parameters:
- W, 32, payload width in bits (concatenated stage fields).
- NOP_PAYLOAD, {W{1'b0}}, payload driven on reset, on flush and whenever out_valid=0.
- SKID, 1, 0 = single entry with combinational in_ready; 1 = two entries with registered in_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash stage contents.
- stall  in  1  hold stage; blocks accept and release.
- in_valid  in  1  upstream has data.
- in_ready  out  1  stage can accept.
- in_data  in  W  upstream payload.
- in_commit  in  1  upstream instruction is a real (committable) instruction.
- out_valid  out  1  stage presents data.
- out_ready  in  1  downstream accepts.
- out_data  out  W  payload to downstream.
- out_commit  out  1  commit flag to downstream.
- occupancy  out  2  number of entries held, 0..2.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Priority of events: rst > flush > stall > handshake.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.

Reset and flush:
- Reset (next edge): out_valid=0, out_data=NOP_PAYLOAD, out_commit=0, occupancy=0, skid entry empty. in_ready=1 in the first cycle after reset, unless stall or flush is high.
- Flush:
  - Combinationally, in_ready=0 and out_valid=0 in the flush cycle.
  - At the edge, both entries are cleared, giving the same state as reset. Any input presented that cycle is dropped.
- Reset or flush mid-transfer discards both entries with no partial update.

Stall:
- Combinationally, in_ready=0 and out_valid=0.
- All state (main, skid, out_data, out_commit, occupancy) is held.
- out_data stays visible (debug), but no transfer occurs.

Main entry:
- out_valid = main_valid & ~stall & ~flush.
- out_data and out_commit come from the main entry. When main is empty, out_data=NOP_PAYLOAD and out_commit=0.

SKID=0:
- in_ready = ~stall & ~flush & (~main_valid | out_ready).
- On in_fire, main loads input at the edge.
- On out_fire without in_fire, main clears to NOP.
- occupancy is never 2.

SKID=1:
- in_ready = ~stall & ~flush & ~skid_valid. This is purely registered state plus the control inputs, with no path from out_ready.
- State transitions at the edge:
  - in_fire with main empty: load main.
  - in_fire with main full and out_fire: main loads input.
  - in_fire with main full and no out_fire: input goes to skid; occupancy becomes 2.
  - out_fire with skid full: skid moves to main, skid clears. in_ready was 0, so there is no simultaneous input.
  - out_fire with skid empty and no in_fire: main clears.
- Skid ordering is strictly FIFO; main always holds the older item.

Common to both modes:
- Latency: in_fire to out_valid is 1 cycle when the stage is empty. Throughput is 1 item/cycle when out_ready is held high.
- Stability: while out_valid=1 and out_ready=0, out_data and out_commit must not change.
- out_commit travels with its payload, with identical timing.
- occupancy = main_valid + skid_valid, registered.

Decomposition:
- Shared package (cpu_pipe_pkg):
  - reset PC constant 32'h1c00_0000 and PC+4;
  - NOP field encodings (ALU ADD opcode, rf_wd_sel, dmem_access default);
  - per-stage payload struct typedefs and their widths, so each instance sets W = $bits(struct) and NOP_PAYLOAD = packed NOP struct.
- One sub-module is natural: seg_hs_slot. It holds valid + W-bit data + commit with load, clear-to-NOP and hold controls, and is instantiated once for main and once for skid under generate SKID==1.

Test Plan:
- rst=1 for 2 cycles with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, out_data=0, occupancy=0. in_ready=1 in the first cycle after rst drops.
- SKID=1, out_ready=1, stream 32'h1..32'h8 back-to-back -> out_data 1..8 on consecutive cycles, 1-cycle latency, occupancy stays 1.
- SKID=1, out_ready=0, push 32'hA then 32'hB -> occupancy=2, in_ready=0, out_data=A held stable. out_ready=1 for two cycles -> outputs A then B, then occupancy=0.
- Stall for 3 cycles with occupancy=1 (data 32'h55) -> out_valid=0, in_ready=0, state held. After stall drops, out_valid=1 with 32'h55 and no duplicate.
- Flush together with stall and in_valid (data 32'h77) while occupancy=2 -> next cycle occupancy=0, out_data=NOP_PAYLOAD, out_commit=0, 32'h77 dropped.
- SKID=0, main full, out_ready toggles 1/0 each cycle with continuous input -> in_ready mirrors out_ready combinationally, no loss and no duplication over 16 items.
